// File: rtl/mdu_pkg.sv
// Shared definitions for the parametrised HI/LO multiply/divide unit:
// op encodings, default datapath width, boundary-value constants and the FSM state type.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    // Boundary values at the default width (divide-by-zero quotient, signed overflow dividend)
    localparam logic [MDU_WIDTH-1:0] MDU_ALL_ONES = {MDU_WIDTH{1'b1}};
    localparam logic [MDU_WIDTH-1:0] MDU_MOST_NEG = {1'b1, {(MDU_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Divide class selects DIV_CYCLES instead of MULT_CYCLES
    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Even op codes (mult, div, madd, msub) treat operands as signed
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op[0] == 1'b0);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: computes the next {HI,LO} for any op from
// the operands and the current HI/LO, including divide-by-zero and signed overflow results.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_V      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [W2-1:0]           a_ext_s;
    logic [W2-1:0]           b_ext_s;
    logic [W2-1:0]           prod_s;
    logic [W2-1:0]           acc_s;
    logic                    div_zero_s;
    logic                    div_ovf_s;
    logic [WIDTH-1:0]        b_safe_s;
    logic signed [WIDTH-1:0] squo_s;
    logic signed [WIDTH-1:0] srem_s;
    logic [WIDTH-1:0]        uquo_s;
    logic [WIDTH-1:0]        urem_s;

    // Operand extension and the 2*WIDTH product (modular, so signed works via sign extension)
    always_comb begin
        if (mdu_is_signed(op)) begin
            a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {{WIDTH{1'b0}}, a};
            b_ext_s = {{WIDTH{1'b0}}, b};
        end
        prod_s = a_ext_s * b_ext_s;
        acc_s  = {hi, lo};
    end

    // Divider with the divisor forced to 1 on zero/overflow so no undefined division is ever formed
    always_comb begin
        div_zero_s = (b == {WIDTH{1'b0}});
        div_ovf_s  = (op == MDU_DIV) && (a == MOST_NEG_V) && (b == ALL_ONES_V);
        if (div_zero_s || div_ovf_s) begin
            b_safe_s = ONE_V;
        end else begin
            b_safe_s = b;
        end
        squo_s = $signed(a) / $signed(b_safe_s);
        srem_s = $signed(a) % $signed(b_safe_s);
        uquo_s = a / b_safe_s;
        urem_s = a % b_safe_s;
    end

    // Result selection per op
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                {hi_next, lo_next} = prod_s;
            end
            MDU_MADD, MDU_MADDU: begin
                {hi_next, lo_next} = acc_s + prod_s;
            end
            MDU_MSUB, MDU_MSUBU: begin
                {hi_next, lo_next} = acc_s - prod_s;
            end
            MDU_DIV: begin
                if (div_zero_s) begin
                    hi_next = a;
                    lo_next = ALL_ONES_V;
                end else if (div_ovf_s) begin
                    hi_next = {WIDTH{1'b0}};
                    lo_next = a;
                end else begin
                    hi_next = srem_s;
                    lo_next = squo_s;
                end
            end
            MDU_DIVU: begin
                if (div_zero_s) begin
                    hi_next = a;
                    lo_next = ALL_ONES_V;
                end else begin
                    hi_next = urem_s;
                    lo_next = uquo_s;
                end
            end
            default: begin
                hi_next = hi;
                lo_next = lo;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit_param.sv
// Parametrised HI/LO multiply/divide unit for the E stage. The result is computed
// at the start edge and released to HI/LO after MULT_CYCLES or DIV_CYCLES busy cycles.
// Optional feature macro: MULT_DIV_CANCEL_EN adds a cancel input that flushes an
// in-flight operation and blocks IDLE-cycle writes/starts.
module mult_div_unit_param
    import mdu_pkg::*;
#(
    parameter int WIDTH       = MDU_WIDTH,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start,
    input  logic [2:0]       MULT_DIV_OP,
    input  logic             MTHI,
    input  logic             MTLO,
`ifdef MULT_DIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] res_hi_r;
    logic [WIDTH-1:0] res_lo_r;
    logic [WIDTH-1:0] hi_next_s;
    logic [WIDTH-1:0] lo_next_s;
    logic             cancel_s;

`ifdef MULT_DIV_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    mdu_arith #(
        .WIDTH(WIDTH)
    ) u_arith (
        .a      (A),
        .b      (B),
        .op     (MULT_DIV_OP),
        .hi     (hi_r),
        .lo     (lo_r),
        .hi_next(hi_next_s),
        .lo_next(lo_next_s)
    );

    // Counter FSM: IDLE handles MTHI/MTLO or launches, RUN counts down and commits on the final edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            res_hi_r <= {WIDTH{1'b0}};
            res_lo_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cancel_s) begin
                        state_r <= ST_IDLE;
                    end else if (MTHI || MTLO) begin
                        if (MTHI) begin
                            hi_r <= A;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (MTLO) begin
                            lo_r <= A;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end else if (start) begin
                        res_hi_r <= hi_next_s;
                        res_lo_r <= lo_next_s;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                        if (mdu_is_div(MULT_DIV_OP)) begin
                            cnt_r <= CNT_W'(DIV_CYCLES);
                        end else begin
                            cnt_r <= CNT_W'(MULT_CYCLES);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cancel_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_W'(1)) begin
                        hi_r    <= res_hi_r;
                        lo_r    <= res_lo_r;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit_param.sv
// Directed self-checking bench for mult_div_unit_param (default parameters).
module tb_mult_div_unit_param;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [2:0]  MULT_DIV_OP;
    logic        MTHI;
    logic        MTLO;
    logic        cancel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit_param #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .start      (start),
        .MULT_DIV_OP(MULT_DIV_OP),
        .MTHI       (MTHI),
        .MTLO       (MTLO),
`ifdef MULT_DIV_CANCEL_EN
        .cancel     (cancel),
`endif
        .busy       (busy),
        .HI         (HI),
        .LO         (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op; count busy cycles (bounded), flag any HI/LO change while busy.
    // inject_at > 0 drives a stray start+MTHI+MTLO pulse at that busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, output int cycles, output logic changed);
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        MULT_DIV_OP = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi0 = HI; lo0 = LO; cycles = 0; changed = 1'b0;
        while (busy && cycles < 100) begin
            if (HI !== hi0 || LO !== lo0) changed = 1'b1;
            cycles++;
            if (cycles == inject_at) begin
                MULT_DIV_OP = MDU_MULT; A = 32'h0000_0009; B = 32'h0000_0009;
                start = 1'b1; MTHI = 1'b1; MTLO = 1'b1;
            end else begin
                start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
    endtask

    task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
        @(negedge clk);
        A = hv; MTHI = 1'b1;
        @(negedge clk);
        MTHI = 1'b0; A = lv; MTLO = 1'b1;
        @(negedge clk);
        MTLO = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 00000000", HI); end
        n_checks++; if (LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 00000000", LO); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int cyc; logic chg;
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 0, cyc, chg);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 5", cyc); end
        n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL mult_hilo_stable got %b want 0", chg); end
        n_checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", HI, LO); end
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_result got %h_%h want 00000001_fffffffe", HI, LO); end
    endtask

    task automatic test_divu_ignore_start();
        int cyc; logic chg;
        run_op(MDU_DIVU, 32'd100, 32'd7, 4, cyc, chg);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want 10", cyc); end
        n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL divu_hilo_stable got %b want 0", chg); end
        n_checks++; if ({HI, LO} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_result got %h_%h want 00000002_0000000e", HI, LO); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divu_no_relaunch got busy %b want 0", busy); end
    endtask

    task automatic test_accumulate();
        int cyc; logic chg;
        @(negedge clk);
        A = 32'h0000_0001; MTHI = 1'b1;
        @(negedge clk);
        MTHI = 1'b0;
        A = 32'h0000_0002; MTLO = 1'b1;
        @(negedge clk);
        MTLO = 1'b0;
        n_checks++; if ({HI, LO} !== 64'h0000_0001_0000_0002) begin n_fail++; $display("FAIL mthi_mtlo got %h_%h want 00000001_00000002", HI, LO); end
        run_op(MDU_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, chg);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL maddu_busy_cycles got %0d want 5", cyc); end
        n_checks++; if ({HI, LO} !== 64'hFFFF_FFFF_0000_0003) begin n_fail++; $display("FAIL maddu_result got %h_%h want ffffffff_00000003", HI, LO); end
        // Both registers written in one cycle
        @(negedge clk);
        A = 32'h0000_000A; MTHI = 1'b1; MTLO = 1'b1;
        @(negedge clk);
        MTHI = 1'b0; MTLO = 1'b0;
        n_checks++; if ({HI, LO} !== 64'h0000_000A_0000_000A) begin n_fail++; $display("FAIL mthi_mtlo_same got %h_%h want 0000000a_0000000a", HI, LO); end
        write_hilo(32'h0, 32'd10);
        run_op(MDU_MSUB, 32'd3, 32'd4, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL msub_result got %h_%h want ffffffff_fffffffe", HI, LO); end
        run_op(MDU_MADD, 32'hFFFF_FFFE, 32'd5, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFF4) begin n_fail++; $display("FAIL madd_result got %h_%h want ffffffff_fffffff4", HI, LO); end
        write_hilo(32'h0, 32'h0);
        run_op(MDU_MSUBU, 32'hFFFF_FFFF, 32'd1, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'hFFFF_FFFF_0000_0001) begin n_fail++; $display("FAIL msubu_result got %h_%h want ffffffff_00000001", HI, LO); end
    endtask

    task automatic test_div_boundary();
        int cyc; logic chg;
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, chg);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d want 10", cyc); end
        n_checks++; if ({HI, LO} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", HI, LO); end
        run_op(MDU_DIV, 32'd5, 32'd0, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'h0000_0005_FFFF_FFFF) begin n_fail++; $display("FAIL div_by_zero got %h_%h want 00000005_ffffffff", HI, LO); end
        run_op(MDU_DIVU, 32'd9, 32'd0, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'h0000_0009_FFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero got %h_%h want 00000009_ffffffff", HI, LO); end
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, cyc, chg);
        n_checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_negative got %h_%h want ffffffff_fffffffd", HI, LO); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic chg;
        run_op(MDU_MULTU, 32'd6, 32'd7, 0, cyc, chg);
        run_op(MDU_MULTU, 32'd11, 32'd13, 0, cyc, chg);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 5", cyc); end
        n_checks++; if ({HI, LO} !== {32'd0, 32'd143}) begin n_fail++; $display("FAIL b2b_result got %h_%h want 00000000_0000008f", HI, LO); end
    endtask

    task automatic test_mthi_with_start();
        write_hilo(32'h0000_0055, 32'h0000_0066);
        @(negedge clk);
        A = 32'h0000_1234; B = 32'd3; MULT_DIV_OP = MDU_MULTU; MTHI = 1'b1; start = 1'b1;
        @(negedge clk);
        MTHI = 1'b0; start = 1'b0;
        n_checks++; if (HI !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_start_hi got %h want 00001234", HI); end
        n_checks++; if (LO !== 32'h0000_0066) begin n_fail++; $display("FAIL mthi_start_lo got %h want 00000066", LO); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_start_busy got %b want 0", busy); end
        repeat (6) @(negedge clk);
        n_checks++; if (HI !== 32'h0000_1234 || LO !== 32'h0000_0066) begin n_fail++; $display("FAIL mthi_start_no_late got %h_%h want 00001234_00000066", HI, LO); end
    endtask

`ifdef MULT_DIV_CANCEL_EN
    task automatic test_cancel();
        write_hilo(32'h0000_0AAA, 32'h0000_0BBB);
        @(negedge clk);
        A = 32'd100; B = 32'd7; MULT_DIV_OP = MDU_DIVU; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", busy); end
        repeat (12) @(negedge clk);
        n_checks++; if ({HI, LO} !== 64'h0000_0AAA_0000_0BBB) begin n_fail++; $display("FAIL cancel_hilo got %h_%h want 00000aaa_00000bbb", HI, LO); end
        A = 32'h0000_0CCC; MTHI = 1'b1; cancel = 1'b1;
        @(negedge clk);
        MTHI = 1'b0; cancel = 1'b0;
        n_checks++; if (HI !== 32'h0000_0AAA) begin n_fail++; $display("FAIL cancel_idle_mthi got %h want 00000aaa", HI); end
    endtask
`endif

    task automatic test_reset_mid_op();
        write_hilo(32'h0000_0077, 32'h0000_0088);
        @(negedge clk);
        A = 32'd100; B = 32'd7; MULT_DIV_OP = MDU_DIV; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
        n_checks++; if ({HI, LO} !== 64'h0) begin n_fail++; $display("FAIL async_reset_hilo got %h_%h want 0_0", HI, LO); end
        @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++; if ({HI, LO} !== 64'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_late_update got %h_%h busy %b want 0_0 busy 0", HI, LO, busy); end
    endtask

    initial begin
        reset = 1'b1; A = 32'h0; B = 32'h0; start = 1'b0; MULT_DIV_OP = MDU_MULT;
        MTHI = 1'b0; MTLO = 1'b0; cancel = 1'b0;
        test_reset();
        test_mult();
        test_divu_ignore_start();
        test_accumulate();
        test_div_boundary();
        test_back_to_back();
        test_mthi_with_start();
`ifdef MULT_DIV_CANCEL_EN
        test_cancel();
`endif
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
